// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair.
// Shift-add multiply and restoring divide on magnitudes, one bit per RUN cycle,
// followed by a FIX cycle for sign correction and the HI/LO write.
// Optional feature macro: MULDIV_EARLY_OUT_EN (multiply leaves RUN once the
// remaining multiplier magnitude bits are all zero).
module muldiv_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             mf_req,
  input  logic             mf_sel,
  input  logic             mt_we,
  input  logic             mt_sel,
  input  logic [WIDTH-1:0] mt_data,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mf_data
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               state_q;
  logic                 is_div_q;
  logic                 neg_lo_q;   // negate product / quotient in FIX
  logic                 neg_hi_q;   // negate remainder in FIX
  logic                 done_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   acc_q;      // product accumulator; low half is remainder for divide
  logic [2*WIDTH-1:0]   mc_q;       // multiplicand shifted left each step; low half is divisor
  logic [WIDTH-1:0]     mp_q;       // multiplier shifted right; dividend shifting into quotient
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;

  logic                 signed_op;
  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [2*WIDTH-1:0]   mul_acc_d;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_trial;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_rem_d;
  logic [WIDTH-1:0]     div_quo_d;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;
  logic                 last_iter;

  // Operand magnitudes, one datapath step, sign correction and loop exit
  always_comb begin
    signed_op = ~op[0];
    a_neg     = signed_op & opa[WIDTH-1];
    b_neg     = signed_op & opb[WIDTH-1];
    a_mag     = a_neg ? -opa : opa;
    b_mag     = b_neg ? -opb : opb;

    mul_acc_d = acc_q + (mp_q[0] ? mc_q : '0);

    div_shift = {acc_q[WIDTH-1:0], mp_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, mc_q[WIDTH-1:0]};
    div_ge    = ~div_trial[WIDTH];
    div_rem_d = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_quo_d = {mp_q[WIDTH-2:0], div_ge};

    prod_fix  = neg_lo_q ? -acc_q : acc_q;
    quo_fix   = neg_lo_q ? -mp_q : mp_q;
    rem_fix   = neg_hi_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

    last_iter = (cnt_q == CW'(WIDTH - 1));
`ifdef MULDIV_EARLY_OUT_EN
    if (!is_div_q && (mp_q[WIDTH-1:1] == '0)) begin
      last_iter = 1'b1;
    end
`endif
  end

  // Sequencer FSM with datapath registers and architectural HI/LO
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mc_q     <= '0;
      mp_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !flush) begin
            state_q  <= S_RUN;
            is_div_q <= op[1];
            cnt_q    <= '0;
            acc_q    <= '0;
            // A zero divisor must leave the all-ones quotient unnegated;
            // a zero multiplier gives a zero product, so the gate is harmless there.
            neg_lo_q <= (a_neg ^ b_neg) & (opb != '0);
            neg_hi_q <= a_neg;
            if (op[1]) begin
              mc_q <= {{WIDTH{1'b0}}, b_mag};
              mp_q <= a_mag;
            end else begin
              mc_q <= {{WIDTH{1'b0}}, a_mag};
              mp_q <= b_mag;
            end
          end else if (mt_we && !start) begin
            if (mt_sel) begin
              hi_q <= mt_data;
            end else begin
              lo_q <= mt_data;
            end
          end
        end
        S_RUN: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (is_div_q) begin
              acc_q <= {{WIDTH{1'b0}}, div_rem_d};
              mp_q  <= div_quo_d;
            end else begin
              acc_q <= mul_acc_d;
              mc_q  <= mc_q << 1;
              mp_q  <= mp_q >> 1;
            end
            if (last_iter) begin
              state_q <= S_FIX;
            end
          end
        end
        S_FIX: begin
          state_q <= S_IDLE;
          if (!flush) begin
            done_q <= 1'b1;
            if (is_div_q) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign stall   = busy & (start | mf_req | mt_we);
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign mf_data = mf_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed and randomized checks of muldiv_ctrl against an
// arithmetic reference model of MULT/MULTU/DIV/DIVU and MT/MF behaviour.
module tb_muldiv_ctrl;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  opa;
  logic [W-1:0]  opb;
  logic          mf_req;
  logic          mf_sel;
  logic          mt_we;
  logic          mt_sel;
  logic [W-1:0]  mt_data;
  logic          flush;
  logic          busy;
  logic          stall;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic [W-1:0]  mf_data;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] model_hi;
  logic [W-1:0] model_lo;

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .opa     (opa),
    .opb     (opb),
    .mf_req  (mf_req),
    .mf_sel  (mf_sel),
    .mt_we   (mt_we),
    .mt_sel  (mt_sel),
    .mt_data (mt_data),
    .flush   (flush),
    .busy    (busy),
    .stall   (stall),
    .done    (done),
    .hi      (hi),
    .lo      (lo),
    .mf_data (mf_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural result of one operation
  task automatic ref_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] h, output logic [W-1:0] l);
    longint      sp;
    logic [63:0] up;
    int          sa;
    int          sb;
    sa = a;
    sb = b;
    case (o)
      2'b00: begin
        sp = longint'(sa) * longint'(sb);
        up = sp;
        h  = up[63:32];
        l  = up[31:0];
      end
      2'b01: begin
        up = {32'h0, a} * {32'h0, b};
        h  = up[63:32];
        l  = up[31:0];
      end
      2'b10: begin
        if (b == 0) begin
          h = a; l = '1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          h = '0; l = 32'h8000_0000;
        end else begin
          l = sa / sb;
          h = sa % sb;
        end
      end
      default: begin
        if (b == 0) begin
          h = a; l = '1;
        end else begin
          l = a / b;
          h = a % b;
        end
      end
    endcase
  endtask

  // Cycles from the start edge to the done cycle
  function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] b);
    logic [W-1:0] m;
    int k;
    bit early;
    m = (o == 2'b00 && b[W-1]) ? -b : b;
    k = 1;
    for (int i = 0; i < W; i++) if (m[i]) k = i + 1;
    early = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
    early = 1'b1;
`endif
    return (early && !o[1]) ? k + 2 : W + 2;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return W'($urandom_range(0, 15));
      default: return W'($urandom());
    endcase
  endfunction

  // Issue one operation from IDLE and leave the bench in its done cycle
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag);
    int n;
    logic [W-1:0] eh;
    logic [W-1:0] el;
    ref_op(o, a, b, eh, el);
    start = 1'b1; op = o; opa = a; opb = b;
    tick();
    start = 1'b0; mt_we = 1'b0; opa = W'($urandom()); opb = W'($urandom());
    n = 1;
    check({tag, "_busy1"}, busy, 1'b1);
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, exp_lat(o, b));
    check({tag, "_hi"}, hi, eh);
    check({tag, "_lo"}, lo, el);
    check({tag, "_busy0"}, busy, 1'b0);
    mf_sel = 1'b0;
    #0;
    check({tag, "_mf"}, mf_data, el);
    model_hi = eh;
    model_lo = el;
  endtask

  initial begin
    int n;
    int bad;
    int ndone;
    logic [W-1:0] sv_hi;
    logic [W-1:0] sv_lo;
    logic [W-1:0] d;

    rst = 1'b1; start = 1'b0; op = '0; opa = '0; opb = '0;
    mf_req = 1'b0; mf_sel = 1'b0; mt_we = 1'b0; mt_sel = 1'b0; mt_data = '0; flush = 1'b0;
    tick(); tick();
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    model_hi = '0; model_lo = '0;
    tick();

    // MTLO then MTHI in IDLE
    mt_we = 1'b1; mt_sel = 1'b0; mt_data = 32'h1234_5678;
    tick();
    mt_we = 1'b0;
    check("mtlo_lo", lo, 32'h1234_5678);
    check("mtlo_hi", hi, 0);
    mt_we = 1'b1; mt_sel = 1'b1; mt_data = 32'hA5A5_0F0F;
    tick();
    mt_we = 1'b0; mf_sel = 1'b1;
    #0;
    check("mthi_mf", mf_data, 32'hA5A5_0F0F);
    check("mthi_lo", lo, 32'h1234_5678);
    tick();

    // Directed arithmetic cases; the second runs back-to-back from the first done cycle
    run_op(2'b00, 32'hFFFF_FFFE, 32'd3, "mult_neg");
    tick(); check("done_pulse", done, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg");
    run_op(2'b11, 32'd7, 32'd0, "divu_zero");
    tick(); check("done_pulse2", done, 0);
    run_op(2'b10, 32'hFFFF_FFFB, 32'd0, "div_zero");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(2'b01, 32'd5, 32'd2, "multu_small");
    tick();

    // start together with MT in IDLE: start wins
    mt_we = 1'b1; mt_sel = 1'b0; mt_data = 32'hDEAD_BEEF;
    run_op(2'b01, 32'd9, 32'd9, "start_mt");
    tick();

    // MFHI and MTHI presented while busy
    start = 1'b1; op = 2'b01; opa = 32'h0001_0000; opb = 32'h0001_0000;
    tick();
    start = 1'b0;
    mf_req = 1'b1; mf_sel = 1'b1; mt_we = 1'b1; mt_sel = 1'b1; mt_data = 32'hCAFE_F00D;
    n = 1; bad = 0;
    while (done !== 1'b1 && n < 100) begin
      if (stall !== 1'b1) bad++;
      tick();
      n++;
    end
    check("mf_stall_cycles", bad, 0);
    check("mf_lat", n, exp_lat(2'b01, 32'h0001_0000));
    check("mf_stall_end", stall, 0);
    check("mf_data_new", mf_data, 1);
    mt_we = 1'b0; mf_req = 1'b0;
    tick();
    check("mt_dropped_hi", hi, 1);
    model_hi = 32'd1; model_lo = '0;

    // Flush at cycle 10 of a DIV
    run_op(2'b11, 32'd1000, 32'd7, "pre_flush");
    tick();
    sv_hi = hi; sv_lo = lo;
    start = 1'b1; op = 2'b10; opa = 32'hFFFF_F000; opb = 32'd13;
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_done", done, 0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) ndone++;
      tick();
    end
    check("flush_no_done", ndone, 0);
    check("flush_hi", hi, sv_hi);
    check("flush_lo", lo, sv_lo);

    // flush together with start in IDLE: not accepted
    start = 1'b1; flush = 1'b1; op = 2'b00; opa = 32'd3; opb = 32'd4;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", busy, 0);

    // rst at cycle 5 of a MULT
    start = 1'b1; op = 2'b00; opa = 32'd123; opb = 32'hFFFF_FF00;
    tick();
    start = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_hi", hi, 0);
    check("rst_mid_lo", lo, 0);
    model_hi = '0; model_lo = '0;
    tick();

    // Randomized operations with interleaved MT writes
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        d = W'($urandom());
        mt_we = 1'b1; mt_sel = 1'($urandom_range(0, 1)); mt_data = d;
        if (mt_sel) model_hi = d; else model_lo = d;
        tick();
        mt_we = 1'b0;
        check($sformatf("rnd%0d_mt_hi", i), hi, model_hi);
        check($sformatf("rnd%0d_mt_lo", i), lo, model_lo);
      end
      run_op(2'($urandom_range(0, 3)), pick(), pick(), $sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 0) begin
        tick();
        check($sformatf("rnd%0d_done_off", i), done, 0);
      end
    end
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Iterative multiply/divide sequencer owning the HI/LO register pair for MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO. It sits beside the EX stage. It accepts one operation at a time, runs a shift-add or restoring-divide datapath for WIDTH cycles, then applies sign correction and writes HI/LO. While busy, it raises `stall` so the pipeline holds any HI/LO-dependent instruction in EX, reusing the PC/IF hold path of the decode hazard logic.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each WIDTH bits.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  EX holds a MULT/MULTU/DIV/DIVU.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `opa`, `opb`  in  WIDTH  rs and rt operand values (dividend and divisor for divide).
- `mf_req`  in  1  EX holds an MFHI or MFLO.
- `mf_sel`  in  1  register select for `mf_data`: 0 selects LO, 1 selects HI.
- `mt_we`  in  1  EX holds an MTHI or MTLO.
- `mt_sel`  in  1  register select for the write: 0 selects LO, 1 selects HI.
- `mt_data`  in  WIDTH  write data for MTHI/MTLO.
- `flush`  in  1  kill the in-flight operation (branch or exception flush of EX).
- `busy`  out  1  state is not IDLE.
- `stall`  out  1  combinational: `busy & (start | mf_req | mt_we)`.
- `done`  out  1  one-cycle pulse; HI/LO hold new results in this cycle.
- `hi`, `lo`  out  WIDTH  architectural HI/LO registers.
- `mf_data`  out  WIDTH  combinational: `mf_sel ? hi : lo`.

## Operation
- Reset: state IDLE; `hi`, `lo`, the iteration counter and the working registers are all 0; `busy` and `done` are 0.
- States and transitions:
  - IDLE → RUN when `start & ~flush`.
  - RUN → FIX after the counter reaches WIDTH iterations.
  - FIX → IDLE unconditionally.
- Accept (IDLE, `start`):
  - Latch `op`.
  - For signed ops, latch |opa| and |opb|, plus the result signs: product sign = sign(opa) XOR sign(opb); remainder sign = sign(opa).
  - Clear the counter.
- RUN, multiply: each cycle, one bit of shift-add into a 2·WIDTH accumulator.
- RUN, divide: each cycle, one restoring step, producing one quotient bit.
- FIX:
  - Multiply: negate the 2·WIDTH product if its sign bit is set. HI ← upper half, LO ← lower half.
  - Divide: LO ← quotient and HI ← remainder, each negated by its own sign.
  - `done` registers to 1 at this edge.
- Divide by zero (opb = 0), both signed and unsigned: LO = all ones, HI = opa. This is decided behaviour and must not be flagged.
- Signed overflow (0x80000000 / 0xFFFFFFFF): LO = 0x80000000, HI = 0.
- MT in IDLE (`mt_we & ~start`): the selected register ← `mt_data` at the edge. The other register is unchanged.
- `start` and `mt_we` together in IDLE: `start` wins; the MT write is dropped.
- `start`, `mf_req` or `mt_we` while busy:
  - Not accepted; `stall` = 1.
  - The request is presented again once `busy` = 0.
  - MF never returns a stale value.
- `flush` in RUN or FIX: the next state is IDLE, `hi`/`lo` are unchanged, and no `done` pulse is produced.
- `flush` together with `start` in IDLE: the operation is not accepted.
- `rst` mid-operation: full reset values next cycle; the operation is lost.

## Timing
- Cycle 0: `start` sampled in IDLE.
- Cycles 1..WIDTH: RUN. Cycle WIDTH+1: FIX. `busy` = 1 throughout cycles 1..WIDTH+1.
- Cycle WIDTH+2: `busy` = 0, `done` = 1, new `hi`/`lo` visible.
- With WIDTH = 32, results appear 34 cycles after `start`.
- A dependent MF stalls until cycle WIDTH+2 and reads the new value that same cycle.
- `done` is high for exactly one cycle. `start` in that cycle is accepted (back-to-back operation).
- MT write latency: 1 cycle. The new value is visible on `hi`/`lo`/`mf_data` in the next cycle.
- `stall` and `mf_data` are combinational from the inputs and registers, with no added latency.

## Configuration
- `MULDIV_EARLY_OUT_EN` defined:
  - MULT/MULTU leave RUN for FIX as soon as the remaining unprocessed multiplier magnitude bits are all zero, evaluated each RUN cycle.
  - Minimum RUN length is 1 cycle.
  - Divide latency is unchanged.
- `MULDIV_EARLY_OUT_EN` undefined: every operation takes exactly WIDTH RUN cycles.

## Test plan
- MULT: opa = 0xFFFFFFFE (−2), opb = 3. Expect `done` at cycle 34, HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
  - With EARLY_OUT, MULTU 5×2 gives `done` at cycle ≤ 5, HI = 0, LO = 10.
- DIV: −7 / 2. Expect LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - DIVU 7 / 0 gives LO = 0xFFFFFFFF, HI = 7.
- MFHI issued at cycle 1 of a MULTU 0x10000×0x10000. Expect `stall` = 1 for cycles 1..33, `stall` = 0 and `mf_data` = 1 at cycle 34.
- MTLO 0x12345678 in IDLE. Expect LO = 0x12345678 next cycle with HI unchanged.
  - MTHI during RUN: `stall` = 1 and no write occurs.
- `flush` at cycle 10 of a DIV. Expect IDLE at cycle 11, no `done`, and HI/LO equal to their pre-start values.
- `rst` at cycle 5 of a MULT. Expect `busy` = 0 and HI = LO = 0 at the next cycle.
- Back-to-back: `start` in the `done` cycle. Expect the second op accepted, with its `done` exactly WIDTH+2 cycles later.
